// File: rtl/gray_seek_ctrl_if.sv
// Command and counter-side signals of the Gray seek controller.
// slave = the controller; master = command source plus counter.
interface gray_seek_ctrl_if #(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_target;
  logic [1:0]        cmd_mode;
  logic              cmd_preset;
  logic              abort;
  logic [WIDTH-1:0]  ctr_gray;
  logic              ctr_dir;
  logic              ctr_en;
  logic              ctr_set;
  logic              done;
  logic [1:0]        status;
  logic [STEP_W-1:0] steps_taken;

  modport master (
    output cmd_valid, cmd_target, cmd_mode, cmd_preset, abort, ctr_gray,
    input  cmd_ready, ctr_dir, ctr_en, ctr_set, done, status, steps_taken
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_mode, cmd_preset, abort, ctr_gray,
    output cmd_ready, ctr_dir, ctr_en, ctr_set, done, status, steps_taken
  );
endinterface

// File: rtl/gray_seek_ctrl.sv
// Seek controller for a WIDTH-bit up/down Gray counter. Takes one command at a
// time, optionally presets the counter, picks a direction, then enables the
// counter until its Gray output hits the target, an abort, or the step limit.
module gray_seek_ctrl #(
  parameter int WIDTH     = 3,
  parameter int MAX_STEPS = 8,
  parameter int STEP_W    = $clog2(MAX_STEPS+1)
) (
  input logic             clk,
  input logic             async_reset_n,
  gray_seek_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRESET, S_DIR, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0]  HALF  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [STEP_W-1:0] LIMIT = STEP_W'(MAX_STEPS);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;
  localparam logic [1:0] ST_TOUT  = 2'b10;

  state_t            r_state;
  logic [WIDTH-1:0]  r_tgt;
  logic [1:0]        r_mode;
  logic              r_preset;
  logic [STEP_W-1:0] r_steps;
  logic              r_dir;
  logic              r_done;
  logic [1:0]        r_status;
  logic [STEP_W-1:0] r_steps_taken;

  logic [WIDTH-1:0]  w_cur_bin;
  logic [WIDTH-1:0]  w_tgt_bin;
  logic [WIDTH-1:0]  w_up_dist;
  logic              w_dir;
  logic              w_match;
  logic              w_steps_ok;
  logic              w_run_en;
  logic              w_set;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign w_cur_bin  = g2b(bus.ctr_gray);
  assign w_tgt_bin  = g2b(r_tgt);
  assign w_up_dist  = w_tgt_bin - w_cur_bin;
  assign w_match    = (bus.ctr_gray == r_tgt);
  assign w_steps_ok = (r_steps < LIMIT);

  // Direction choice; mode 11 falls back to shortest path, half-ring tie goes up
  always_comb begin
    w_dir = 1'b1;
    case (r_mode)
      2'b01:   w_dir = 1'b1;
      2'b10:   w_dir = 1'b0;
      default: w_dir = (w_up_dist <= HALF);
    endcase
  end

  // Enable is combinational so the counter stops on the exact edge it matches
  assign w_run_en = (r_state == S_RUN) && !w_match && !bus.abort && w_steps_ok;
  assign w_set    = (r_state == S_PRESET) && !bus.abort;

  assign bus.ctr_en      = w_run_en || w_set;
  assign bus.ctr_set     = w_set;
  assign bus.ctr_dir     = r_dir;
  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.done        = r_done;
  assign bus.status      = r_status;
  assign bus.steps_taken = r_steps_taken;

  // Command FSM; done/status/steps_taken are loaded on the way into DONE
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_state       <= S_IDLE;
      r_tgt         <= '0;
      r_mode        <= 2'b00;
      r_preset      <= 1'b0;
      r_steps       <= '0;
      r_dir         <= 1'b0;
      r_done        <= 1'b0;
      r_status      <= ST_OK;
      r_steps_taken <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_tgt    <= bus.cmd_target;
            r_mode   <= bus.cmd_mode;
            r_preset <= bus.cmd_preset;
            r_steps  <= '0;
            r_status <= ST_OK;
            r_state  <= bus.cmd_preset ? S_PRESET : S_DIR;
          end
        end
        S_PRESET: begin
          if (bus.abort) begin
            r_status      <= ST_ABORT;
            r_steps_taken <= r_steps;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_state <= S_DIR;
          end
        end
        S_DIR: begin
          if (bus.abort) begin
            r_status      <= ST_ABORT;
            r_steps_taken <= r_steps;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_dir   <= w_dir;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Every exit happens on a cycle with ctr_en=0, so r_steps is final
          if (bus.abort) begin
            r_status      <= ST_ABORT;
            r_steps_taken <= r_steps;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else if (w_match) begin
            r_status      <= ST_OK;
            r_steps_taken <= r_steps;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else if (!w_steps_ok) begin
            r_status      <= ST_TOUT;
            r_steps_taken <= r_steps;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_steps <= r_steps + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
